otp_auth_fsm: RTL and testbench
===============================

# otp_auth_fsm

Session controller for the OTP authenticator, directly upstream of the seven-segment display stage. It generates a one-time password from a free-running 16-bit LFSR and captures the user's submitted code. It tracks wrong attempts, an OTP validity timer and a lockout timer. It drives `unlock`, `lock`, `expire`, `wrng_att`, `user_otp` and `lfsr_otp`, which the display stage consumes unchanged.

## Interface

Parameters:

- `TIMEOUT_CYC`, default 1000: OTP validity window, in clock cycles.
- `LOCK_CYC`, default 5000: lockout duration, in clock cycles.
- `MAX_ATT`, default 3: wrong attempts that cause lockout; legal range 1..3.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `gen_req`  in  1  single-cycle pulse: start a session with a new OTP.
- `submit`  in  1  single-cycle pulse: `user_in` holds the entered code.
- `user_in`  in  16  code entered by the user.
- `user_otp`  out  16  last submitted code, registered.
- `lfsr_otp`  out  16  OTP of the current session, registered.
- `unlock`  out  1  high in UNLOCKED.
- `lock`  out  1  high in LOCKED.
- `expire`  out  1  high in EXPIRED.
- `wrng_att`  out  2  wrong attempts in the current session; saturates at 3.

## Operation

- **LFSR**
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Feedback = s[0]^s[2]^s[3]^s[5]; next = {fb, s[15:1]}.
  - Advances every cycle and is never zero.
  - `gen_req` copies its current value into `lfsr_otp`.
- **States:** IDLE, WAIT_OTP, UNLOCKED, EXPIRED, LOCKED. Reset state is IDLE.
- **IDLE**
  - All flags 0.
  - `gen_req` → capture the OTP, clear the timer, clear `wrng_att`, go to WAIT_OTP.
- **WAIT_OTP**
  - The validity timer increments each cycle.
  - On `submit`: latch `user_in` into `user_otp` and compare it with `lfsr_otp`.
    - Equal → UNLOCKED.
    - Unequal → `wrng_att`+1. If the new count equals MAX_ATT → LOCKED (clear the timer); otherwise stay.
  - Timer reaches TIMEOUT_CYC-1 → EXPIRED.
  - `gen_req` is ignored.
- **UNLOCKED**
  - `unlock`=1.
  - `gen_req` → new session (same action as from IDLE).
  - `submit` is ignored.
- **EXPIRED**
  - `expire`=1.
  - `gen_req` → new session.
  - `submit` is ignored; `user_otp` is not updated.
- **LOCKED**
  - `lock`=1; the lockout timer counts.
  - `gen_req` and `submit` are ignored.
  - Timer reaches LOCK_CYC-1 → IDLE, clearing `wrng_att` and `lfsr_otp`.
- **Simultaneous events**
  - `submit` and timeout in the same cycle → EXPIRED. The submission is discarded and `user_otp` is not updated.
  - `gen_req` and `submit` together in IDLE, UNLOCKED or EXPIRED → `gen_req` acts, `submit` is ignored.
- **Timer widths:** clog2 of the respective parameter; no wrap is possible because each timer is cleared on state entry.

## Timing

- Reset values:
  - LFSR = LFSR_SEED.
  - `lfsr_otp` = 0 and `user_otp` = 0.
  - `unlock` = `lock` = `expire` = 0.
  - `wrng_att` = 0.
  - State = IDLE.
- All outputs are registered, Moore-style. Flags decode from the state register and become valid the cycle after the sampling edge.
- `gen_req` at edge N: `lfsr_otp` equals the LFSR value just before edge N, visible from cycle N+1.
- `submit` at edge N: `user_otp`, `wrng_att` and state update at edge N, visible from cycle N+1. There is no wait state.
- Expiry: `expire` rises exactly TIMEOUT_CYC cycles after WAIT_OTP entry.
- Lockout: `lock` stays high for exactly LOCK_CYC cycles.
- Reset asserted mid-session: all state and outputs return to reset values immediately. Timers are lost.

## Structure

- Shared package/header `otp_pkg`: state encodings (3-bit), LFSR tap positions, default seed.
- One sub-module `otp_lfsr` (clk, rstn, 16-bit `q`; seed parameter).
- Everything else (FSM, both timers, comparator, capture registers) lives in `otp_auth_fsm`.

## Test plan

1. **Reset and first OTP:** reset, then `gen_req` on the first edge after `rstn` rises → `lfsr_otp`=16'hACE1; `gen_req` one cycle later instead → 16'h5670.
2. **Correct entry:** `gen_req`, then `submit` with `user_in`=`lfsr_otp` at cycle 10 → `user_otp` matches, `unlock`=1 next cycle, `wrng_att`=0.
3. **Lockout:** three wrong submits (16'h0000, 16'h1234, 16'hFFFF) → `wrng_att` 1, 2, then `lock`=1. `lock` holds for LOCK_CYC cycles with `gen_req` ignored, then IDLE with `wrng_att`=0.
4. **Expiry:** TIMEOUT_CYC=8, `gen_req`, no submit → `expire`=1 exactly 8 cycles after WAIT_OTP entry. A later correct submit is ignored; `gen_req` starts a new session.
5. **Submit coinciding with timeout:** correct `submit` on the timeout cycle → EXPIRED, `unlock` stays 0, `user_otp` unchanged.
6. **Reset mid-session:** `rstn` low during LOCKED with `wrng_att`=3 → all outputs 0 asynchronously; the next `gen_req` restarts from the seed sequence.

Source files
------------

// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared state encodings, LFSR taps and seed for the OTP authenticator
package otp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_OTP = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_EXPIRED  = 3'd3,
    ST_LOCKED   = 3'd4
  } otp_state_e;

  localparam logic [15:0] OTP_DEFAULT_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  localparam int LFSR_TAP_A = 0;
  localparam int LFSR_TAP_B = 2;
  localparam int LFSR_TAP_C = 3;
  localparam int LFSR_TAP_D = 5;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic w_fb;
    w_fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D];
    return {w_fb, s[15:1]};
  endfunction

endpackage

// File: rtl/otp_lfsr.sv
// rtl/otp_lfsr.sv - free-running 16-bit Fibonacci LFSR, one step per clock
module otp_lfsr
  import otp_pkg::*;
#(
  parameter logic [15:0] SEED = OTP_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= SEED;
    end else begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/otp_auth_fsm.sv
// rtl/otp_auth_fsm.sv - OTP session controller: capture, compare, attempt count, validity and lockout timers
module otp_auth_fsm
  import otp_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 1000,
  parameter int          LOCK_CYC    = 5000,
  parameter int          MAX_ATT     = 3,
  parameter logic [15:0] LFSR_SEED   = OTP_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        gen_req,
  input  logic        submit,
  input  logic [15:0] user_in,
  output logic [15:0] user_otp,
  output logic [15:0] lfsr_otp,
  output logic        unlock,
  output logic        lock,
  output logic        expire,
  output logic [1:0]  wrng_att
);

  localparam int VTW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LTW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [VTW-1:0] VT_LAST = VTW'(TIMEOUT_CYC - 1);
  localparam logic [LTW-1:0] LT_LAST = LTW'(LOCK_CYC - 1);

  otp_state_e     r_state, w_state_nxt;
  logic [VTW-1:0] r_vtmr, w_vtmr_nxt;
  logic [LTW-1:0] r_ltmr, w_ltmr_nxt;
  logic [15:0]    r_lfsr_otp, w_lfsr_otp_nxt;
  logic [15:0]    r_user_otp, w_user_otp_nxt;
  logic [1:0]     r_wrng_att, w_wrng_att_nxt;
  logic [15:0]    w_lfsr;
  logic [1:0]     w_att_inc;

  otp_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .q    (w_lfsr)
  );

  assign w_att_inc = (r_wrng_att == 2'd3) ? 2'd3 : r_wrng_att + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_vtmr     <= '0;
      r_ltmr     <= '0;
      r_lfsr_otp <= '0;
      r_user_otp <= '0;
      r_wrng_att <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vtmr     <= w_vtmr_nxt;
      r_ltmr     <= w_ltmr_nxt;
      r_lfsr_otp <= w_lfsr_otp_nxt;
      r_user_otp <= w_user_otp_nxt;
      r_wrng_att <= w_wrng_att_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_vtmr_nxt     = r_vtmr;
    w_ltmr_nxt     = r_ltmr;
    w_lfsr_otp_nxt = r_lfsr_otp;
    w_user_otp_nxt = r_user_otp;
    w_wrng_att_nxt = r_wrng_att;
    case (r_state)
      ST_IDLE, ST_UNLOCKED, ST_EXPIRED: begin
        if (gen_req) begin
          w_state_nxt    = ST_WAIT_OTP;
          w_vtmr_nxt     = '0;
          w_wrng_att_nxt = '0;
          w_lfsr_otp_nxt = w_lfsr;
        end
      end
      ST_WAIT_OTP: begin
        w_vtmr_nxt = r_vtmr + VTW'(1);
        // timeout wins over a same-cycle submit, which is then dropped
        if (r_vtmr == VT_LAST) begin
          w_state_nxt = ST_EXPIRED;
        end else if (submit) begin
          w_user_otp_nxt = user_in;
          if (user_in == r_lfsr_otp) begin
            w_state_nxt = ST_UNLOCKED;
          end else begin
            w_wrng_att_nxt = w_att_inc;
            if (w_att_inc == 2'(MAX_ATT)) begin
              w_state_nxt = ST_LOCKED;
              w_ltmr_nxt  = '0;
            end
          end
        end
      end
      ST_LOCKED: begin
        w_ltmr_nxt = r_ltmr + LTW'(1);
        if (r_ltmr == LT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_wrng_att_nxt = '0;
          w_lfsr_otp_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign unlock   = (r_state == ST_UNLOCKED);
  assign lock     = (r_state == ST_LOCKED);
  assign expire   = (r_state == ST_EXPIRED);
  assign user_otp = r_user_otp;
  assign lfsr_otp = r_lfsr_otp;
  assign wrng_att = r_wrng_att;

endmodule

// File: tb/tb_otp_auth_fsm.sv
// tb/tb_otp_auth_fsm.sv - directed self-checking bench for otp_auth_fsm
module tb_otp_auth_fsm;

  localparam int TO = 8;
  localparam int LK = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        gen_req = 1'b0;
  logic        submit = 1'b0;
  logic [15:0] user_in = 16'h0000;
  logic [15:0] user_otp, lfsr_otp;
  logic        unlock, lock, expire;
  logic [1:0]  wrng_att;

  otp_auth_fsm #(.TIMEOUT_CYC(TO), .LOCK_CYC(LK), .MAX_ATT(3), .LFSR_SEED(16'hACE1)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .gen_req  (gen_req),
    .submit   (submit),
    .user_in  (user_in),
    .user_otp (user_otp),
    .lfsr_otp (lfsr_otp),
    .unlock   (unlock),
    .lock     (lock),
    .expire   (expire),
    .wrng_att (wrng_att)
  );

  always #5 clk = ~clk;

  // reference LFSR built from the polynomial, used to predict captured OTPs
  logic [15:0] m_lfsr;
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= ref_next(m_lfsr);
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] flags();
    return {13'b0, unlock, lock, expire};
  endfunction

  logic [15:0] otp;
  logic [15:0] wrong [3];
  int n;

  initial begin
    wrong[0] = 16'h0000;
    wrong[1] = 16'h1234;
    wrong[2] = 16'hFFFF;

    #12;
    @(negedge clk);
    check("rst_lfsr_otp", lfsr_otp, 16'h0000);
    check("rst_user_otp", user_otp, 16'h0000);
    check("rst_flags", flags(), 16'h0000);
    check("rst_wrng", 16'(wrng_att), 16'h0000);

    // gen_req on the first edge after reset release
    rstn = 1'b1; gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    check("otp_first_edge", lfsr_otp, 16'hACE1);
    check("wait_flags", flags(), 16'h0000);

    // gen_req one edge later
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    tick;
    gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    check("otp_second_edge", lfsr_otp, 16'h5670);

    // correct entry
    tick;
    tick;
    submit = 1'b1; user_in = 16'h5670;
    tick;
    submit = 1'b0;
    check("ok_user_otp", user_otp, 16'h5670);
    check("ok_flags", flags(), 16'h0004);
    check("ok_wrng", 16'(wrng_att), 16'h0000);

    // lockout from UNLOCKED via a new session
    otp = m_lfsr;
    gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    check("s2_otp", lfsr_otp, otp);
    check("s2_flags", flags(), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      submit = 1'b1; user_in = wrong[i];
      tick;
      submit = 1'b0;
      check("bad_wrng", 16'(wrng_att), 16'(i + 1));
      check("bad_flags", flags(), (i == 2) ? 16'h0002 : 16'h0000);
    end
    n = 0;
    while (lock && n < LK + 10) begin
      n++;
      if (n == 3) begin
        gen_req = 1'b1; submit = 1'b1; user_in = otp;
      end
      tick;
      gen_req = 1'b0; submit = 1'b0;
      if (n == 5) begin
        check("lock_otp_held", lfsr_otp, otp);
        check("lock_wrng_held", 16'(wrng_att), 16'h0003);
        check("lock_user_held", user_otp, 16'hFFFF);
      end
    end
    check("lock_len", 16'(n), 16'(LK));
    check("unlock_idle_flags", flags(), 16'h0000);
    check("unlock_idle_wrng", 16'(wrng_att), 16'h0000);
    check("unlock_idle_otp", lfsr_otp, 16'h0000);

    // expiry
    otp = m_lfsr;
    gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    n = 0;
    while (!expire && n < 50) begin
      tick;
      n++;
    end
    check("expire_delay", 16'(n), 16'(TO));
    check("expire_flags", flags(), 16'h0001);
    submit = 1'b1; user_in = otp;
    tick;
    submit = 1'b0;
    check("exp_submit_user", user_otp, 16'hFFFF);
    check("exp_submit_flags", flags(), 16'h0001);
    otp = m_lfsr;
    gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    check("regen_otp", lfsr_otp, otp);
    check("regen_flags", flags(), 16'h0000);

    // correct submit on the timeout cycle
    repeat (TO - 1) tick;
    check("pre_timeout_flags", flags(), 16'h0000);
    submit = 1'b1; user_in = otp;
    tick;
    submit = 1'b0;
    check("race_flags", flags(), 16'h0001);
    check("race_user", user_otp, 16'hFFFF);

    // reset during lockout
    gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      submit = 1'b1; user_in = wrong[i];
      tick;
      submit = 1'b0;
    end
    check("pre_rst_flags", flags(), 16'h0002);
    check("pre_rst_wrng", 16'(wrng_att), 16'h0003);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_flags", flags(), 16'h0000);
    check("async_rst_wrng", 16'(wrng_att), 16'h0000);
    check("async_rst_lfsr_otp", lfsr_otp, 16'h0000);
    check("async_rst_user_otp", user_otp, 16'h0000);
    @(negedge clk);
    rstn = 1'b1; gen_req = 1'b1;
    tick;
    gen_req = 1'b0;
    check("post_rst_otp", lfsr_otp, 16'hACE1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
